// File: rtl/sram_like_arbiter.sv
// Two-to-one sram-like arbiter: inst and data miss paths share one master port.
// Data has priority; a grant streak counter keeps inst fetches from starving.
module sram_like_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic [31:0] inst_rdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,

    output logic        m_req,
    output logic        m_wr,
    output logic [1:0]  m_size,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_addr_ok,
    input  logic        m_data_ok
);

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA
    } state_e;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_e     state_q, state_d;
    logic       owner_q, owner_d;
    logic [3:0] streak_q, streak_d;

    logic data_win;
    logic addr_hit;
    logic done;

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        streak_d = streak_q;
        addr_hit = 1'b0;
        done     = 1'b0;
        // inst only overrides data once data has won LIMIT times in a row
        data_win = data_req && !(inst_req && streak_q == LIMIT);
        unique case (state_q)
            IDLE: begin
                if (data_win) begin
                    state_d = ADDR;
                    owner_d = 1'b1;
                    if (inst_req && streak_q < LIMIT) begin
                        streak_d = streak_q + 4'd1;
                    end
                end else if (inst_req) begin
                    state_d  = ADDR;
                    owner_d  = 1'b0;
                    streak_d = 4'd0;
                end
            end
            ADDR: begin
                addr_hit = m_addr_ok;
                if (m_addr_ok) begin
                    done    = m_data_ok;
                    state_d = m_data_ok ? IDLE : DATA;
                end
            end
            DATA: begin
                done = m_data_ok;
                if (m_data_ok) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            streak_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            streak_q <= streak_d;
        end
    end

    assign m_req   = (state_q == ADDR);
    assign m_wr    = m_req & (owner_q ? data_wr : inst_wr);
    assign m_size  = {2{m_req}} & (owner_q ? data_size : inst_size);
    assign m_addr  = {32{m_req}} & (owner_q ? data_addr : inst_addr);
    assign m_wdata = {32{m_req}} & (owner_q ? data_wdata : inst_wdata);

    assign inst_addr_ok = addr_hit & ~owner_q;
    assign data_addr_ok = addr_hit & owner_q;
    assign inst_data_ok = done & ~owner_q;
    assign data_data_ok = done & owner_q;

    assign inst_rdata = m_rdata;
    assign data_rdata = m_rdata;

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Bench for sram_like_arbiter: directed scenarios plus random traffic,
// all checked cycle by cycle against a transaction-level model.
module tb_sram_like_arbiter;

    localparam int LIM = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
    logic [31:0] inst_rdata, data_rdata;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic        m_req, m_wr;
    logic [1:0]  m_size;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic        m_addr_ok, m_data_ok;

    int n_cmp = 0;
    int n_bad = 0;

    // model: is a transaction open, has its address been taken, who owns it
    bit busy, taken, who;
    int streak;
    bit last_iaok, last_daok, last_rst;
    logic grants[$];

    always #5 clk = ~clk;

    sram_like_arbiter #(.STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_rdata(inst_rdata), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_rdata(data_rdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok),
        .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_rdata(m_rdata), .m_addr_ok(m_addr_ok),
        .m_data_ok(m_data_ok)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // inputs are set at posedge+1; outputs checked and model advanced at negedge
    task automatic step();
        bit          issuing, aok, dok;
        logic [2:0]  ectl;
        logic [31:0] eaddr, ewdata;
        #4;
        issuing = busy && !taken;
        ectl = '0;
        eaddr = '0;
        ewdata = '0;
        if (issuing) begin
            ectl   = who ? {data_wr, data_size} : {inst_wr, inst_size};
            eaddr  = who ? data_addr : inst_addr;
            ewdata = who ? data_wdata : inst_wdata;
        end
        aok = issuing && m_addr_ok;
        dok = busy && m_data_ok && (taken || m_addr_ok);
        check("m_req", m_req, issuing);
        check("m_ctl", {m_wr, m_size}, ectl);
        check("m_addr", m_addr, eaddr);
        check("m_wdata", m_wdata, ewdata);
        check("inst_addr_ok", inst_addr_ok, aok && !who);
        check("data_addr_ok", data_addr_ok, aok && who);
        check("inst_data_ok", inst_data_ok, dok && !who);
        check("data_data_ok", data_data_ok, dok && who);
        if (dok && !who) check("inst_rdata", inst_rdata, m_rdata);
        if (dok && who) check("data_rdata", data_rdata, m_rdata);
        check("streak", dut.streak_q, streak);
        if (inst_addr_ok === 1'b1) grants.push_back(1'b0);
        if (data_addr_ok === 1'b1) grants.push_back(1'b1);
        last_iaok = aok && !who;
        last_daok = aok && who;
        last_rst  = rst;
        if (rst) begin
            busy = 0; taken = 0; who = 0; streak = 0;
        end else if (!busy) begin
            if (data_req && !(inst_req && streak == LIM)) begin
                busy = 1; who = 1;
                if (inst_req) streak = (streak + 1 > LIM) ? LIM : streak + 1;
            end else if (inst_req) begin
                busy = 1; who = 0; streak = 0;
            end
        end else if (!taken) begin
            if (m_addr_ok) begin
                if (m_data_ok) busy = 0;
                else taken = 1;
            end
        end else if (m_data_ok) begin
            busy = 0; taken = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        inst_req = 0; inst_wr = 0; inst_size = 0; inst_addr = 0; inst_wdata = 0;
        data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
        m_addr_ok = 0; m_data_ok = 0; m_rdata = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        step();
        rst = 0;
        grants.delete();
    endtask

    function automatic logic [7:0] order(input int n);
        logic [7:0] v = '0;
        for (int i = 0; i < n; i++) begin
            v = {v[6:0], (i < grants.size()) ? grants[i] : 1'bx};
        end
        return v;
    endfunction

    task automatic drive_rand();
        rst = ($urandom_range(0, 199) == 0);
        if (inst_req && (last_iaok || last_rst)) inst_req = 0;
        if (data_req && (last_daok || last_rst)) data_req = 0;
        if (!inst_req && $urandom_range(0, 3) == 0) begin
            inst_req = 1; inst_wr = 1'($urandom); inst_size = 2'($urandom);
            inst_addr = $urandom; inst_wdata = $urandom;
        end
        if (!data_req && $urandom_range(0, 2) == 0) begin
            data_req = 1; data_wr = 1'($urandom); data_size = 2'($urandom);
            data_addr = $urandom; data_wdata = $urandom;
        end
        m_addr_ok = ($urandom_range(0, 2) == 0);
        m_data_ok = ($urandom_range(0, 2) == 0);
        m_rdata   = $urandom;
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        busy = 0; taken = 0; who = 0; streak = 0;
        @(posedge clk);
        #1;
        do_reset();

        // single inst read with a wait state on each phase
        inst_req = 1; inst_size = 2; inst_addr = 32'hBFC00000;
        step();
        step();
        m_addr_ok = 1;
        step();
        m_addr_ok = 0; inst_req = 0;
        step();
        m_data_ok = 1; m_rdata = 32'h3C1D0000;
        step();
        m_data_ok = 0;
        step();
        check("t1_order", order(1), 8'b0);

        // simultaneous requests: data first, then inst
        do_reset();
        inst_req = 1; inst_addr = 32'h1000;
        data_req = 1; data_addr = 32'h2000;
        step();
        m_addr_ok = 1; m_data_ok = 1;
        step();
        data_req = 0;
        step();
        step();
        inst_req = 0; m_addr_ok = 0; m_data_ok = 0;
        step();
        check("t2_order", order(2), 8'b10);

        // both held high: inst breaks through after LIM data grants
        do_reset();
        inst_req = 1; inst_addr = 32'h3000;
        data_req = 1; data_addr = 32'h4000;
        m_addr_ok = 1; m_data_ok = 1;
        repeat (12) step();
        check("t3_order", order(6), 8'b00111101);
        check("t3_count", grants.size(), 6);

        // data write completing in one ADDR cycle
        do_reset();
        data_req = 1; data_wr = 1; data_size = 2;
        data_addr = 32'h80001000; data_wdata = 32'hDEADBEEF;
        step();
        m_addr_ok = 1; m_data_ok = 1;
        step();
        data_req = 0; m_addr_ok = 0; m_data_ok = 0;
        step();
        check("t4_order", order(1), 8'b1);

        // spurious data_ok in IDLE, then reset mid-transaction
        do_reset();
        m_data_ok = 1;
        step();
        step();
        m_data_ok = 0; inst_req = 1; inst_addr = 32'h5000;
        step();
        m_addr_ok = 1;
        step();
        inst_req = 0; m_addr_ok = 0;
        step();
        rst = 1;
        step();
        rst = 0; m_data_ok = 1;
        step();
        m_data_ok = 0; inst_req = 1; inst_addr = 32'h6000;
        step();
        m_addr_ok = 1; m_data_ok = 1;
        step();
        inst_req = 0; m_addr_ok = 0; m_data_ok = 0;
        step();
        check("t5_order", order(2), 8'b00);

        // random traffic
        do_reset();
        last_iaok = 0; last_daok = 0; last_rst = 0;
        repeat (3000) begin
            drive_rand();
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
